// File: rtl/div_control_if.sv
// ----------------------------------------------------------------------------
// div_control_if
// Bundles the handshake and control signals between the restoring-divider
// sequencer and the blocks around it: the requester, the remainder register
// and the divisor ALU.
//
//   start            request; the controller samples it only when idle
//   dividend_in      dividend; read by the remainder register load path only
//   divisor_in       divisor; captured by the controller when start is taken
//   alu_carry        1 = remainder_hi >= divisor (the subtract did not borrow)
//   divisor_out      latched divisor, drives ALU operand B
//   w_ctrl_Remainder 0 = load remainder register, 1 = execute shift/subtract
//   sub_ctrl         1 = commit difference and shift in quotient bit 1
//   hold             1 = remainder register keeps its value
//   busy             high from LOAD through the last iteration
//   rdy              one-cycle pulse when quotient/remainder are valid
//   div_by_zero      sticky zero-divisor flag (only with DIV_ZERO_CHECK_EN)
//
// Modports: slave = controller side, master = requester/datapath side.
// ----------------------------------------------------------------------------
interface div_control_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic             alu_carry;
    logic [WIDTH-1:0] divisor_out;
    logic             w_ctrl_Remainder;
    logic             sub_ctrl;
    logic             hold;
    logic             busy;
    logic             rdy;
    logic             div_by_zero;

    // The controller never looks at the dividend; the remainder register
    // reads it directly, so it is left out of the controller view.
    modport slave (
        input  start, divisor_in, alu_carry,
        output divisor_out, w_ctrl_Remainder, sub_ctrl, hold, busy, rdy,
               div_by_zero
    );

    modport master (
        output start, dividend_in, divisor_in, alu_carry,
        input  divisor_out, w_ctrl_Remainder, sub_ctrl, hold, busy, rdy,
               div_by_zero
    );
endinterface

// File: rtl/div_control.sv
// ----------------------------------------------------------------------------
// div_control
// Sequencing controller for a restoring unsigned divider. On an accepted
// start it latches the divisor onto the ALU operand, issues one load command
// to the remainder register, then WIDTH shift/subtract commands steered by the
// ALU no-borrow flag, and finally pulses rdy for one cycle.
//
// Ports:
//   clk   clock; state advances on posedge (the datapath samples on negedge,
//         so the decoded controls settle half a cycle before they are used)
//   rst   asynchronous, active-low reset
//   bus   div_control_if.slave (start/divisor in, datapath controls out)
//
// Build option:
//   DIV_ZERO_CHECK_EN  when defined, a zero divisor at start bypasses
//                      LOAD/ITER, goes straight to DONE and sets div_by_zero.
//                      When undefined, div_by_zero is tied low and a zero
//                      divisor runs the normal WIDTH iterations.
// ----------------------------------------------------------------------------
module div_control #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    div_control_if.slave       bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] divisor_q;
    logic             accept;
    logic             zero_div;

    logic w_ctrl_d, sub_d, hold_d, busy_d, rdy_d;

    assign accept = (state == IDLE) && bus.start;

`ifdef DIV_ZERO_CHECK_EN
    assign zero_div = (bus.divisor_in == '0);
`else
    assign zero_div = 1'b0;
`endif

    // State and iteration counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Divisor is captured only on accept, so later divisor_in changes cannot
    // disturb an operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        divisor_q <= '0;
        else if (accept) divisor_q <= bus.divisor_in;
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dz_q;

    // Sticky until the next accepted start, which reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        dz_q <= 1'b0;
        else if (accept) dz_q <= zero_div;
    end

    assign bus.div_by_zero = dz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    // Next state plus control decode. Controls depend only on the state
    // register (and alu_carry in ITER), never on start.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        w_ctrl_d  = 1'b1;
        sub_d     = 1'b0;
        hold_d    = 1'b1;
        busy_d    = 1'b0;
        rdy_d     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = zero_div ? DONE : LOAD;
                    count_nxt = '0;
                end
            end
            LOAD: begin
                w_ctrl_d  = 1'b0;
                hold_d    = 1'b0;
                busy_d    = 1'b1;
                count_nxt = '0;
                state_nxt = ITER;
            end
            ITER: begin
                hold_d    = 1'b0;
                busy_d    = 1'b1;
                // Carry from the current remainder settles before the
                // datapath negedge, so it can steer this same cycle.
                sub_d     = bus.alu_carry;
                count_nxt = count + CW'(1);
                if (count == LAST) state_nxt = DONE;
            end
            DONE: begin
                rdy_d     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.divisor_out      = divisor_q;
    assign bus.w_ctrl_Remainder = w_ctrl_d;
    assign bus.sub_ctrl         = sub_d;
    assign bus.hold             = hold_d;
    assign bus.busy             = busy_d;
    assign bus.rdy              = rdy_d;
endmodule

// File: tb/tb_div_control.sv
// ----------------------------------------------------------------------------
// tb_div_control
// Directed bench for div_control with a behavioural restoring-divider
// datapath (remainder register clocked on negedge, ALU carry combinational).
// ----------------------------------------------------------------------------
module tb_div_control;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_control_if #(.WIDTH(WIDTH)) bus ();

    div_control #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural datapath: {m_hi, m_lo} is the remainder register.
    logic [WIDTH-1:0] m_hi = '0;
    logic [WIDTH-1:0] m_lo = '0;
    logic [WIDTH:0]   m_shift;

    assign m_shift       = {m_hi, m_lo[WIDTH-1]};
    assign bus.alu_carry = (m_shift >= {1'b0, bus.divisor_out});

    always @(negedge clk) begin
        if (!bus.hold) begin
            if (!bus.w_ctrl_Remainder) begin
                m_hi <= '0;
                m_lo <= bus.dividend_in;
            end else begin
                m_hi <= bus.sub_ctrl ? WIDTH'(m_shift - {1'b0, bus.divisor_out})
                                     : m_shift[WIDTH-1:0];
                m_lo <= {m_lo[WIDTH-2:0], bus.sub_ctrl};
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one division from IDLE (caller sits at posedge+1). Returns the
    // rdy cycle relative to the accept edge (N+lat), counts of ITER and LOAD
    // cycles, and sub_ctrl disagreements. Optionally pulses start again when
    // the iteration counter equals restart_at. Leaves the DUT back in IDLE.
    task automatic run_op(input logic [31:0] dd, input logic [31:0] dv,
                          input int restart_at, output int lat,
                          output int iters, output int loads,
                          output int sub_bad);
        lat = 0; iters = 0; loads = 0; sub_bad = 0;
        bus.dividend_in = dd;
        bus.divisor_in  = dv;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.divisor_in = ~dv;
        for (int k = 0; k < 100; k++) begin
            if (!bus.w_ctrl_Remainder) loads++;
            if (bus.busy && bus.w_ctrl_Remainder) begin
                iters++;
                if (bus.sub_ctrl !== bus.alu_carry) sub_bad++;
                bus.start = (iters == restart_at + 1);
            end else if (bus.sub_ctrl !== 1'b0) begin
                sub_bad++;
            end
            if (bus.rdy) begin
                lat = k + 1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        int          restart;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, iters, loads, sub_bad, n;
        int t_rdy[3];
        int l_cnt[3];
        int nr;
        logic [31:0] q_save;

        vecs[0] = '{32'd100,        32'd7,          -1, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          10, 32'hFFFF_FFFF,  32'd0};
        vecs[2] = '{32'd1000,       32'd5,          -1, 32'd200,        32'd0};
        vecs[3] = '{32'd7,          32'd100,        -1, 32'd0,          32'd7};
        vecs[4] = '{32'h1234_5678,  32'h0000_1000,  -1, 32'h0001_2345,  32'h678};
        vecs[5] = '{32'hFFFF_FFFF,  32'h0001_0000,  -1, 32'h0000_FFFF,  32'hFFFF};
        vecs[6] = '{32'd0,          32'd5,          -1, 32'd0,          32'd0};
        vecs[7] = '{32'd9,          32'd3,          20, 32'd3,          32'd0};

        bus.start       = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;

        // Reset and idle.
        #1;
        check("rst_hold", bus.hold, 1);
        check("rst_wctrl", bus.w_ctrl_Remainder, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold", bus.hold, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_rdy", bus.rdy, 0);
        check("idle_wctrl", bus.w_ctrl_Remainder, 1);
        check("idle_sub", bus.sub_ctrl, 0);
        check("idle_divisor_out", bus.divisor_out, 0);
        check("idle_dz", bus.div_by_zero, 0);

        // Table-driven divisions.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].dd, vecs[i].dv, vecs[i].restart, lat, iters, loads,
                   sub_bad);
            check($sformatf("v%0d_latency", i), lat, WIDTH + 2);
            check($sformatf("v%0d_iters", i), iters, WIDTH);
            check($sformatf("v%0d_loads", i), loads, 1);
            check($sformatf("v%0d_sub_ctrl", i), sub_bad, 0);
            check($sformatf("v%0d_quot", i), m_lo, vecs[i].q);
            check($sformatf("v%0d_rem", i), m_hi, vecs[i].r);
            check($sformatf("v%0d_divisor_out", i), bus.divisor_out,
                  vecs[i].dv);
            check($sformatf("v%0d_dz", i), bus.div_by_zero, 0);
        end

        // Asynchronous reset in the middle of the iterations (count 17).
        bus.dividend_in = 32'd100;
        bus.divisor_in  = 32'd7;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy && bus.w_ctrl_Remainder) n++;
            if (n == 18) break;
            @(posedge clk); #1;
        end
        check("mid_reach_count17", n, 18);
        rst = 1'b0;
        #1;
        check("mid_rst_hold", bus.hold, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rdy", bus.rdy, 0);
        check("mid_rst_wctrl", bus.w_ctrl_Remainder, 1);
        check("mid_rst_sub", bus.sub_ctrl, 0);
        check("mid_rst_divisor_out", bus.divisor_out, 0);
        check("mid_rst_dz", bus.div_by_zero, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(32'd9, 32'd3, -1, lat, iters, loads, sub_bad);
        check("post_rst_latency", lat, WIDTH + 2);
        check("post_rst_iters", iters, WIDTH);
        check("post_rst_quot", m_lo, 3);
        check("post_rst_rem", m_hi, 0);

        // start held high: back-to-back operations.
        bus.dividend_in = 32'd50;
        bus.divisor_in  = 32'd5;
        bus.start       = 1'b1;
        nr = 0;
        l_cnt = '{0, 0, 0};
        t_rdy = '{0, 0, 0};
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!bus.w_ctrl_Remainder) l_cnt[nr]++;
            if (bus.rdy) begin
                t_rdy[nr] = k;
                nr++;
                if (nr == 3) break;
            end
        end
        bus.start = 1'b0;
        q_save = m_lo;
        check("b2b_rdy_count", nr, 3);
        check("b2b_period_1", t_rdy[1] - t_rdy[0], WIDTH + 3);
        check("b2b_period_2", t_rdy[2] - t_rdy[1], WIDTH + 3);
        check("b2b_loads_0", l_cnt[0], 1);
        check("b2b_loads_1", l_cnt[1], 1);
        check("b2b_loads_2", l_cnt[2], 1);
        check("b2b_quot", q_save, 10);
        check("b2b_rem", m_hi, 0);
        repeat (2) @(posedge clk);
        #1;

        // Zero divisor.
`ifdef DIV_ZERO_CHECK_EN
        q_save = m_lo;
        run_op(32'd123, 32'd0, -1, lat, iters, loads, sub_bad);
        check("dz_latency", lat, 1);
        check("dz_iters", iters, 0);
        check("dz_loads", loads, 0);
        check("dz_flag", bus.div_by_zero, 1);
        check("dz_rem_reg_untouched", m_lo, q_save);
        repeat (3) @(posedge clk);
        #1;
        check("dz_sticky", bus.div_by_zero, 1);
        run_op(32'd9, 32'd3, -1, lat, iters, loads, sub_bad);
        check("dz_cleared", bus.div_by_zero, 0);
        check("dz_next_quot", m_lo, 3);
`else
        run_op(32'd123, 32'd0, -1, lat, iters, loads, sub_bad);
        check("dz_latency", lat, WIDTH + 2);
        check("dz_iters", iters, WIDTH);
        check("dz_loads", loads, 1);
        check("dz_flag", bus.div_by_zero, 0);
        check("dz_quot", m_lo, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
